imem_loader: RTL

- Writes instruction memory from a byte stream, so it is the writer side of the core's fetch path.
- It assembles DATA_WIDTH-bit instruction words from little-endian bytes and writes them to consecutive instruction-memory addresses starting at 0.
- It holds the pipeline in reset for the whole load.
- It sits between the board-level byte source (UART or JTAG bridge) and the instruction_memory write port, beside datapath_unit.

---
 rtl/imem_loader_pkg.sv | 10 +
 rtl/word_assembler.sv | 52 +++++
 rtl/imem_loader.sv | 138 +++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and helpers for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} loader_state_t;

    function automatic int bytes_per_word(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/word_assembler.sv
// rtl/word_assembler.sv - packs little-endian stream bytes into one instruction word
module word_assembler
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  accept,
    input  logic [7:0]            s_data,
    output logic [DATA_WIDTH-1:0] word_next,
    output logic                  word_complete,
    output logic                  pad_hit
);
    localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
    localparam int IDX_W          = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int LAST_BITS      = DATA_WIDTH - 8 * (BYTES_PER_WORD - 1);
    localparam logic [7:0] PAD_MASK = 8'hFF << LAST_BITS;

    logic [DATA_WIDTH-1:0] asm_word;
    logic [IDX_W-1:0]      byte_idx;
    logic                  last_byte;

    assign last_byte = (byte_idx == IDX_W'(BYTES_PER_WORD - 1));

    // Bits of the last byte beyond DATA_WIDTH have no slot, so they fall away here.
    always_comb begin
        word_next = asm_word;
        for (int b = 0; b < DATA_WIDTH; b++) begin
            if (byte_idx == IDX_W'(b / 8)) begin
                word_next[b] = s_data[3'(b % 8)];
            end
        end
    end

    assign word_complete = accept && last_byte;
    assign pad_hit       = word_complete && (|(s_data & PAD_MASK));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            asm_word <= '0;
            byte_idx <= '0;
        end else if (clear) begin
            byte_idx <= '0;
        end else if (accept) begin
            asm_word <= word_next;
            byte_idx <= last_byte ? '0 : byte_idx + 1'b1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads instruction memory from a byte stream while holding the core in reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DATA_WIDTH    = 20,
    parameter int ADDRESS_WIDTH = 8,
    parameter int MEM_SIZE      = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [ADDRESS_WIDTH:0]   word_count,
    input  logic                     s_valid,
    input  logic [7:0]               s_data,
    output logic                     s_ready,
    output logic                     imem_we,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    output logic [DATA_WIDTH-1:0]    imem_wdata,
    output logic                     core_rst_n,
    output logic                     busy,
    output logic                     done,
    output logic                     cfg_error,
    output logic                     pad_error
);
    localparam int CNT_W = ADDRESS_WIDTH + 1;

    loader_state_t            state, state_next;
    logic [CNT_W-1:0]         count, count_next;
    logic [ADDRESS_WIDTH-1:0] addr, addr_next, imem_addr_next;
    logic [DATA_WIDTH-1:0]    imem_wdata_next, word_next;
    logic                     cfg_error_next, pad_error_next;
    logic                     asm_clear, accept, word_complete, pad_hit, count_legal;

    // An abort cancels any byte offered in the same cycle.
    assign accept      = s_valid && s_ready && !abort;
    assign count_legal = (word_count != '0) && (word_count <= CNT_W'(MEM_SIZE));

    word_assembler #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_word_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear        (asm_clear),
        .accept       (accept),
        .s_data       (s_data),
        .word_next    (word_next),
        .word_complete(word_complete),
        .pad_hit      (pad_hit)
    );

    always_comb begin
        state_next      = state;
        count_next      = count;
        addr_next       = addr;
        imem_addr_next  = imem_addr;
        imem_wdata_next = imem_wdata;
        cfg_error_next  = 1'b0;
        pad_error_next  = pad_error;
        asm_clear       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count_legal) begin
                        state_next     = RECV;
                        count_next     = word_count;
                        addr_next      = '0;
                        pad_error_next = 1'b0;
                        asm_clear      = 1'b1;
                    end else begin
                        cfg_error_next = 1'b1;
                    end
                end
            end
            RECV: begin
                if (abort) begin
                    state_next = IDLE;
                    asm_clear  = 1'b1;
                end else if (word_complete) begin
                    state_next      = WRITE;
                    imem_addr_next  = addr;
                    imem_wdata_next = word_next;
                    if (pad_hit) begin
                        pad_error_next = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (abort) begin
                    state_next = IDLE;
                end else if ({1'b0, addr} == count - 1'b1) begin
                    state_next = DONE;
                end else begin
                    addr_next  = addr + 1'b1;
                    state_next = RECV;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs are derived from the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            count      <= '0;
            addr       <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_rst_n <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_error  <= 1'b0;
            pad_error  <= 1'b0;
        end else begin
            state      <= state_next;
            count      <= count_next;
            addr       <= addr_next;
            s_ready    <= (state_next == RECV);
            imem_we    <= (state_next == WRITE);
            imem_addr  <= imem_addr_next;
            imem_wdata <= imem_wdata_next;
            core_rst_n <= (state_next == IDLE);
            busy       <= (state_next != IDLE);
            done       <= (state_next == DONE);
            cfg_error  <= cfg_error_next;
            pad_error  <= pad_error_next;
        end
    end

endmodule
